div_mult_unit: RTL and testbench
================================

# div_mult_unit

Sequential signed multiply/divide unit that answers the control unit's MULT/DIV requests. It latches two 32-bit operands on a start pulse and iterates for 32 cycles: radix-2 Booth for MULT, restoring division on magnitudes for DIV. It then writes the 64-bit result into HI/LO and pulses `done`. A DIV with a zero divisor is reported on `div_zero` instead of being computed; the control unit raises the exception from that flag.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the counter and result widths derive from it.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_in` input 1: reset is synchronous and active-low.
- `start` input 1: request pulse, sampled only in IDLE.
- `Div_Mult_Ctrl` input 1: operation select, sampled with `start`; 0 = MULT, 1 = DIV.
- `a_in` input 32: rs operand (multiplicand / dividend), two's complement.
- `b_in` input 32: rt operand (multiplier / divisor), two's complement.
- `hi` output 32: HI register. MULT gives product[63:32]; DIV gives the remainder.
- `lo` output 32: LO register. MULT gives product[31:0]; DIV gives the quotient.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; `hi`/`lo` are updated.
- `div_zero` output 1: one-cycle pulse; DIV requested with `b_in == 0`.

## Operation
- Reset (`reset_in == 0` at a rising edge):
  - state goes to IDLE;
  - `hi`, `lo`, the counter and all working registers are cleared to 0;
  - `busy`, `done` and `div_zero` are 0.
  - Reset overrides `start` and aborts any operation in flight; no partial result reaches `hi`/`lo`.
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- IDLE with `start == 1`:
  - MULT: operands are captured, `busy` is set, the counter is loaded with 0, and state goes to MUL_RUN.
  - DIV with `b_in != 0`: same, except the operands are first converted to magnitudes, their signs are latched, and state goes to DIV_RUN.
  - DIV with `b_in == 0`: `div_zero` is set for one cycle, `hi`/`lo` are unchanged, `busy` stays 0, and state stays IDLE.
- MUL_RUN, per cycle (Booth):
  - Work register is {A_acc[32:0], Q[31:0], q_1}, with A_acc 33-bit to hold the sign.
  - Examine {Q[0], q_1}: 01 adds the multiplicand, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic-shift the whole register right by 1.
  - After 32 iterations, state goes to FINISH.
- DIV_RUN, per cycle (restoring, unsigned magnitudes):
  - Shift {R, Q} left by 1 and trial-subtract the divisor magnitude from R.
  - If the result is non-negative, keep it and set Q[0] = 1; otherwise restore and set Q[0] = 0.
  - After 32 iterations, state goes to FINISH.
- FINISH, single cycle:
  - MULT: `hi` = product[63:32], `lo` = product[31:0].
  - DIV: `lo` = Q negated if sign(a) XOR sign(b); `hi` = R negated if sign(a). This is truncation toward zero, matching MIPS.
  - Pulse `done`, clear `busy`, return to IDLE.
- Arithmetic rules:
  - Magnitude of 0x80000000 is the unsigned value 2^31, with no overflow in the datapath.
  - DIV 0x80000000 / 0xFFFFFFFF wraps: `lo` = 0x80000000, `hi` = 0.
- Operands are captured at the start edge; later changes on `a_in`/`b_in`/`Div_Mult_Ctrl` are ignored.
- `start` while `busy` or in FINISH is ignored, with no queueing.

## Timing
- Let E0 be the edge that samples `start`.
- `busy` is 1 from after E0 until E33.
- E1–E32 perform the 32 iterations.
- E33 writes `hi`/`lo` and sets `done`. `done` is high for exactly the cycle E33–E34.
- Latency from E0 to valid `hi`/`lo` is 33 cycles.
- `start` in the cycle after `done` is accepted immediately, giving back-to-back operations every 34 cycles.
- Div-by-zero: `div_zero` is high for the cycle E0–E1 only. `done` is never asserted for that request.
- `hi`/`lo` change only at a FINISH edge or at reset, and hold otherwise.

## Test plan
- Reset, then MULT 7 × 0xFFFFFFFD (−3):
  - `done` pulses exactly 33 cycles after the start edge;
  - `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB;
  - `busy` is high for 33 cycles.
- MULT 0x80000000 × 0x80000000 → `hi` = 0x40000000, `lo` = 0x00000000.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1).
- DIV 7 / 0xFFFFFFFE (−2):
  - → `lo` = 0xFFFFFFFD, `hi` = 1.
  - Then back-to-back DIV 0x80000000 / 0xFFFFFFFF, with `start` in the cycle after the first `done` → `lo` = 0x80000000, `hi` = 0.
- Start/operand/zero-divisor edges:
  - With prior `hi`/`lo` = 0x11111111/0x22222222, DIV 5 / 0 → `div_zero` is a one-cycle pulse at E0–E1, `busy` stays 0, no `done`, and `hi`/`lo` are unchanged.
  - `start` pulses during a MULT in flight are ignored, and the result matches the original operands.
  - Operands changed after E0 do not affect the result.
- Reset mid-operation:
  - Assert `reset_in` = 0 at iteration 15 of a MULT → the next edge gives `busy` = 0, `hi` = `lo` = 0, and no `done` ever.
  - A fresh MULT 3 × 4 then gives `lo` = 12, `hi` = 0.
  - `start` together with `reset_in` = 0 → the request is discarded.

Source files
------------

// File: rtl/div_mult_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring
// division on magnitudes, 32 iterations each, result delivered to HI/LO.
module div_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             Div_Mult_Ctrl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MUL_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH:0]   r_mcand;
    logic             r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

    // Operand magnitudes; 0x80000000 maps to unsigned 2^31 without overflow
    always_comb begin
        w_abs_a = a_in[WIDTH-1] ? ({WIDTH{1'b0}} - a_in) : a_in;
        w_abs_b = b_in[WIDTH-1] ? ({WIDTH{1'b0}} - b_in) : b_in;
    end

    // Booth step: 33-bit accumulator keeps the sign of +/- multiplicand
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_mcand;
            2'b10:   w_booth_sum = r_acc - r_mcand;
            default: w_booth_sum = r_acc;
        endcase
    end

    // Restoring-division trial subtract and final sign fix-up (truncate toward zero)
    always_comb begin
        w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_trial = w_shift - r_mcand;
        w_quot  = (r_sign_a ^ r_sign_b) ? ({WIDTH{1'b0}} - r_q) : r_q;
        w_rem   = r_sign_a ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_acc      <= {(WIDTH+1){1'b0}};
            r_q        <= {WIDTH{1'b0}};
            r_q1       <= 1'b0;
            r_mcand    <= {(WIDTH+1){1'b0}};
            r_op       <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (Div_Mult_Ctrl && (b_in == {WIDTH{1'b0}})) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                            r_cnt  <= {CW{1'b0}};
                            r_acc  <= {(WIDTH+1){1'b0}};
                            r_q1   <= 1'b0;
                            r_op   <= Div_Mult_Ctrl;
                            if (Div_Mult_Ctrl) begin
                                r_q      <= w_abs_a;
                                r_mcand  <= {1'b0, w_abs_b};
                                r_sign_a <= a_in[WIDTH-1];
                                r_sign_b <= b_in[WIDTH-1];
                                r_state  <= S_DIV_RUN;
                            end else begin
                                r_q      <= b_in;
                                r_mcand  <= {a_in[WIDTH-1], a_in};
                                r_sign_a <= 1'b0;
                                r_sign_b <= 1'b0;
                                r_state  <= S_MUL_RUN;
                            end
                        end
                    end
                end
                S_MUL_RUN: begin
                    r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                    r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FINISH;
                    end
                end
                S_DIV_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_acc <= w_trial;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_shift;
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (r_op) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_mult_unit.sv
// Directed self-checking bench for div_mult_unit: latency, signed results,
// back-to-back issue, divide-by-zero, ignored starts and mid-operation reset.
module tb_div_mult_unit;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        start;
    logic        Div_Mult_Ctrl;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_mult_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .start         (start),
        .Div_Mult_Ctrl (Div_Mult_Ctrl),
        .a_in          (a_in),
        .b_in          (b_in),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .done          (done),
        .div_zero      (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request through its start edge E0, then scramble the operand inputs.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b, input string tag);
        start = 1'b1; Div_Mult_Ctrl = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; Div_Mult_Ctrl = ~op;
        chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_wait(input string tag, input logic [31:0] eh, input logic [31:0] el, input bit interfere);
        int lat  = 0;
        int bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (interfere && c >= 3 && c <= 20) start = c[0];
            else start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, 32'd33);
        chk({tag, "_busy_cycles"}, bcnt, 32'd32);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    task automatic watch_idle(input string tag);
        bit saw_done = 1'b0;
        bit saw_busy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        chk({tag, "_no_done"}, {31'd0, saw_done}, 32'd0);
        chk({tag, "_no_busy"}, {31'd0, saw_busy}, 32'd0);
    endtask

    initial begin
        reset_in = 1'b0; start = 1'b0; Div_Mult_Ctrl = 1'b0;
        a_in = 32'd0; b_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        reset_in = 1'b1;
        @(posedge clk); #1;

        // 7 * -3 = -21
        launch(1'b0, 32'h00000007, 32'hFFFFFFFD, "m1");
        finish_wait("m1", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        @(posedge clk); #1;
        chk("m1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("m1_hi_hold", hi, 32'hFFFFFFFF);

        // (-2^31)^2 = 2^62
        launch(1'b0, 32'h80000000, 32'h80000000, "m2");
        finish_wait("m2", 32'h40000000, 32'h00000000, 1'b0);

        // -7 / 2 = -3 rem -1
        launch(1'b1, 32'hFFFFFFF9, 32'h00000002, "d1");
        finish_wait("d1", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

        // 7 / -2 = -3 rem 1, then back-to-back -2^31 / -1 wraps
        launch(1'b1, 32'h00000007, 32'hFFFFFFFE, "d2");
        finish_wait("d2", 32'h00000001, 32'hFFFFFFFD, 1'b0);
        launch(1'b1, 32'h80000000, 32'hFFFFFFFF, "d3");
        finish_wait("d3", 32'h00000000, 32'h80000000, 1'b0);

        // 0x66666666 * 0x2AAAAAAB = 0x11111111_22222222
        launch(1'b0, 32'h66666666, 32'h2AAAAAAB, "m3");
        finish_wait("m3", 32'h11111111, 32'h22222222, 1'b0);

        // Divide by zero
        start = 1'b1; Div_Mult_Ctrl = 1'b1; a_in = 32'd5; b_in = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("dz_pulse", {31'd0, div_zero}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("dz_pulse_end", {31'd0, div_zero}, 32'd0);
        watch_idle("dz");
        chk("dz_hi_keep", hi, 32'h11111111);
        chk("dz_lo_keep", lo, 32'h22222222);

        // Start pulses and operand changes during a MULT are ignored
        launch(1'b0, 32'h00012345, 32'h00000100, "mi");
        finish_wait("mi", 32'h00000000, 32'h01234500, 1'b1);

        // Reset at iteration 15
        launch(1'b0, 32'h00001234, 32'hFFFF0000, "mr");
        repeat (14) @(posedge clk);
        #1;
        reset_in = 1'b0;
        @(posedge clk); #1;
        reset_in = 1'b1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_hi", hi, 32'd0);
        chk("mr_lo", lo, 32'd0);
        watch_idle("mr");

        launch(1'b0, 32'h00000003, 32'h00000004, "m34");
        finish_wait("m34", 32'h00000000, 32'h0000000C, 1'b0);

        // Start together with reset is discarded
        start = 1'b1; reset_in = 1'b0; Div_Mult_Ctrl = 1'b0; a_in = 32'd5; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; reset_in = 1'b1;
        chk("sr_busy", {31'd0, busy}, 32'd0);
        chk("sr_hi", hi, 32'd0);
        chk("sr_lo", lo, 32'd0);
        watch_idle("sr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
